// File: rtl/led_seq_ctrl.sv
// Passcode-gated LED sequencer: animates a pass/fail pattern on 1 Hz ticks, then shows user data or locks out.
// Optional feature macro: LED_SEQ_LOCKOUT_EN adds the consecutive-failure counter and the LOCKOUT state.
module led_seq_ctrl #(
    parameter logic [3:0]  PASSCODE      = 4'b1001,
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned LOCKOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] code,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic [3:0] data_in,
    input  logic       relock,
    output logic [3:0] led,
    output logic       busy,
    output logic       unlocked,
    output logic       locked_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS_SEQ = 3'd1,
        FAIL_SEQ = 3'd2,
        UNLOCKED = 3'd3,
        LOCKOUT  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] led_q, led_d;

`ifdef LED_SEQ_LOCKOUT_EN
    localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);
    localparam logic [3:0] LO_LAST  = 4'(LOCKOUT_TICKS - 1);
    logic [2:0] fail_q, fail_d;
    logic [3:0] tcnt_q, tcnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_FAIL[2:0], LOCKOUT_TICKS[3:0]};
`endif

    function automatic logic [3:0] pass_pat(input logic [3:0] s);
        case (s)
            4'd1, 4'd7: pass_pat = 4'b0001;
            4'd2, 4'd6: pass_pat = 4'b0010;
            4'd3, 4'd5: pass_pat = 4'b0100;
            4'd4:       pass_pat = 4'b1000;
            default:    pass_pat = 4'b0000;
        endcase
    endfunction

    // Odd steps light all LEDs, even steps blank them.
    function automatic logic [3:0] fail_pat(input logic [3:0] s);
        fail_pat = s[0] ? 4'b1111 : 4'b0000;
    endfunction

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        led_d   = 4'b0000;
`ifdef LED_SEQ_LOCKOUT_EN
        fail_d  = fail_q;
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    step_d = 4'd0;
                    if (code == PASSCODE) begin
                        state_d = PASS_SEQ;
`ifdef LED_SEQ_LOCKOUT_EN
                        fail_d  = 3'd0;
`endif
                    end else begin
                        state_d = FAIL_SEQ;
`ifdef LED_SEQ_LOCKOUT_EN
                        fail_d  = (fail_q == FAIL_MAX) ? fail_q : fail_q + 3'd1;
`endif
                    end
                end
            end
            PASS_SEQ: begin
                led_d = pass_pat(step_q);
                if (tick) begin
                    if (step_q == 4'd8) begin
                        state_d = UNLOCKED;
                        step_d  = 4'd0;
                    end else begin
                        step_d  = step_q + 4'd1;
                    end
                end
            end
            FAIL_SEQ: begin
                led_d = fail_pat(step_q);
                if (tick) begin
                    if (step_q == 4'd6) begin
                        step_d  = 4'd0;
`ifdef LED_SEQ_LOCKOUT_EN
                        if (fail_q == FAIL_MAX) begin
                            state_d = LOCKOUT;
                            tcnt_d  = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        step_d  = step_q + 4'd1;
                    end
                end
            end
            UNLOCKED: begin
                // Relock blanks the LEDs on the same edge the state drops to IDLE.
                if (relock) begin
                    state_d = IDLE;
                end else begin
                    led_d   = data_in;
                end
            end
`ifdef LED_SEQ_LOCKOUT_EN
            LOCKOUT: begin
                led_d = 4'b1010;
                if (tick) begin
                    if (tcnt_q == LO_LAST) begin
                        state_d = IDLE;
                        fail_d  = 3'd0;
                        tcnt_d  = 4'd0;
                        led_d   = 4'b0000;
                    end else begin
                        tcnt_d  = tcnt_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            led_q   <= 4'b0000;
`ifdef LED_SEQ_LOCKOUT_EN
            fail_q  <= 3'd0;
            tcnt_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            led_q   <= led_d;
`ifdef LED_SEQ_LOCKOUT_EN
            fail_q  <= fail_d;
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    assign led        = led_q;
    assign code_ready = (state_q == IDLE);
    assign unlocked   = (state_q == UNLOCKED);
`ifdef LED_SEQ_LOCKOUT_EN
    assign busy       = (state_q == PASS_SEQ) || (state_q == FAIL_SEQ) || (state_q == LOCKOUT);
    assign locked_out = (state_q == LOCKOUT);
`else
    assign busy       = (state_q == PASS_SEQ) || (state_q == FAIL_SEQ);
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: pass/fail patterns, unlock/relock, lockout and reset abort.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] code = 4'b0000;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [3:0] data_in = 4'b0000;
    logic       relock = 1'b0;
    logic [3:0] led;
    logic       busy;
    logic       unlocked;
    logic       locked_out;

    int checks = 0;
    int failures = 0;

    led_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .data_in    (data_in),
        .relock     (relock),
        .led        (led),
        .busy       (busy),
        .unlocked   (unlocked),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: all drive/sample points sit 1 time unit after a rising edge.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        clk1();
    endtask

    task automatic send_code(input logic [3:0] c);
        code = c;
        code_valid = 1'b1;
        clk1();
        code_valid = 1'b0;
        clk1();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        clk1();
    endtask

    task automatic run_fail(input logic [3:0] c);
        send_code(c);
        for (int i = 0; i < 7; i++) pulse_tick();
    endtask

    task automatic run_pass_and_relock();
        send_code(4'b1001);
        for (int i = 0; i < 9; i++) pulse_tick();
        relock = 1'b1;
        clk1();
        relock = 1'b0;
        clk1();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({led, busy, unlocked, locked_out} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got led=%b busy=%b unl=%b lo=%b, want all 0",
                     led, busy, unlocked, locked_out);
        end
        @(negedge clk);
        reset = 1'b1;
        clk1();
        checks++;
        if (code_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", code_ready);
        end
    endtask

    task automatic test_pass();
        logic [3:0] exp [0:8];
        exp = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0100, 4'b0010, 4'b0001, 4'b0000};
        apply_reset();
        send_code(4'b1001);
        checks++;
        if (led !== exp[0] || busy !== 1'b1 || code_ready !== 1'b0) begin
            failures++;
            $display("FAIL pass_step0: got led=%b busy=%b rdy=%b want %b 1 0",
                     led, busy, code_ready, exp[0]);
        end
        for (int i = 1; i <= 8; i++) begin
            pulse_tick();
            checks++;
            if (led !== exp[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL pass_step%0d: got led=%b busy=%b want %b 1", i, led, busy, exp[i]);
            end
            if (i == 3) begin
                // A code presented mid-sequence and a stray relock must both be ignored.
                code = 4'b1001;
                code_valid = 1'b1;
                relock = 1'b1;
                clk1();
                code_valid = 1'b0;
                relock = 1'b0;
                clk1();
                checks++;
                if (led !== exp[3] || busy !== 1'b1 || code_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL pass_ignore_code: got led=%b busy=%b rdy=%b want %b 1 0",
                             led, busy, code_ready, exp[3]);
                end
            end
        end
        pulse_tick();
        checks++;
        if (unlocked !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pass_unlock: got unl=%b busy=%b want 1 0", unlocked, busy);
        end
        data_in = 4'b0110;
        clk1();
        checks++;
        if (led !== 4'b0110) begin
            failures++;
            $display("FAIL unlocked_data0: got %b want 0110", led);
        end
        data_in = 4'b1101;
        clk1();
        checks++;
        if (led !== 4'b1101) begin
            failures++;
            $display("FAIL unlocked_data1: got %b want 1101", led);
        end
        relock = 1'b1;
        tick = 1'b1;
        clk1();
        relock = 1'b0;
        tick = 1'b0;
        checks++;
        if (unlocked !== 1'b0 || led !== 4'b0000 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL relock: got unl=%b led=%b rdy=%b want 0 0000 1", unlocked, led, code_ready);
        end
        data_in = 4'b0000;
    endtask

    task automatic test_fail();
        apply_reset();
        send_code(4'b0011);
        checks++;
        if (led !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fail_step0: got led=%b busy=%b want 0000 1", led, busy);
        end
        for (int i = 1; i <= 6; i++) begin
            pulse_tick();
            checks++;
            if (led !== ((i % 2) ? 4'b1111 : 4'b0000)) begin
                failures++;
                $display("FAIL fail_step%0d: got %b want %b", i, led,
                         ((i % 2) ? 4'b1111 : 4'b0000));
            end
        end
        pulse_tick();
        checks++;
        if (busy !== 1'b0 || code_ready !== 1'b1 || led !== 4'b0000 || locked_out !== 1'b0) begin
            failures++;
            $display("FAIL fail_end: got busy=%b rdy=%b led=%b lo=%b want 0 1 0000 0",
                     busy, code_ready, led, locked_out);
        end
    endtask

    task automatic test_lockout();
        apply_reset();
`ifdef LED_SEQ_LOCKOUT_EN
        run_fail(4'b0000);
        run_fail(4'b0111);
        checks++;
        if (locked_out !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL lockout_early: got lo=%b rdy=%b want 0 1", locked_out, code_ready);
        end
        run_fail(4'b1111);
        checks++;
        if (locked_out !== 1'b1 || busy !== 1'b1 || code_ready !== 1'b0) begin
            failures++;
            $display("FAIL lockout_enter: got lo=%b busy=%b rdy=%b want 1 1 0",
                     locked_out, busy, code_ready);
        end
        clk1();
        checks++;
        if (led !== 4'b1010) begin
            failures++;
            $display("FAIL lockout_led: got %b want 1010", led);
        end
        for (int i = 0; i < 9; i++) pulse_tick();
        checks++;
        if (locked_out !== 1'b1 || led !== 4'b1010) begin
            failures++;
            $display("FAIL lockout_hold9: got lo=%b led=%b want 1 1010", locked_out, led);
        end
        pulse_tick();
        checks++;
        if (locked_out !== 1'b0 || code_ready !== 1'b1 || led !== 4'b0000) begin
            failures++;
            $display("FAIL lockout_exit: got lo=%b rdy=%b led=%b want 0 1 0000",
                     locked_out, code_ready, led);
        end
        run_fail(4'b0101);
        checks++;
        if (locked_out !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL lockout_cleared: got lo=%b rdy=%b want 0 1", locked_out, code_ready);
        end
`else
        run_fail(4'b0000);
        run_fail(4'b0111);
        run_fail(4'b1111);
        checks++;
        if (locked_out !== 1'b0 || code_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL nolockout: got lo=%b rdy=%b busy=%b want 0 1 0",
                     locked_out, code_ready, busy);
        end
        run_fail(4'b0101);
        checks++;
        if (locked_out !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL nolockout_more: got lo=%b rdy=%b want 0 1", locked_out, code_ready);
        end
`endif
    endtask

    task automatic test_fail_count_reset();
        apply_reset();
        run_fail(4'b0000);
        run_fail(4'b0001);
        run_pass_and_relock();
        run_fail(4'b0010);
        run_fail(4'b0100);
        checks++;
        if (locked_out !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL failcnt_cleared: got lo=%b rdy=%b want 0 1", locked_out, code_ready);
        end
`ifdef LED_SEQ_LOCKOUT_EN
        run_fail(4'b1000);
        checks++;
        if (locked_out !== 1'b1) begin
            failures++;
            $display("FAIL failcnt_third: got lo=%b want 1", locked_out);
        end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_code(4'b1001);
        for (int i = 0; i < 4; i++) pulse_tick();
        checks++;
        if (led !== 4'b1000) begin
            failures++;
            $display("FAIL midrst_pre: got %b want 1000", led);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0000 || busy !== 1'b0 || unlocked !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: got led=%b busy=%b unl=%b want 0000 0 0", led, busy, unlocked);
        end
        #3;
        reset = 1'b1;
        clk1();
        checks++;
        if (code_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready: got %b want 1", code_ready);
        end
        for (int i = 0; i < 9; i++) pulse_tick();
        checks++;
        if (unlocked !== 1'b0 || led !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_nounlock: got unl=%b led=%b busy=%b want 0 0000 0",
                     unlocked, led, busy);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_lockout();
        test_fail_count_reset();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter PASSCODE, default 4'b1001, code that grants unlock.
REQ-002 Parameter MAX_FAIL, default 3, consecutive wrong codes before lockout (range 1..7).
REQ-003 Parameter LOCKOUT_TICKS, default 10, tick count spent in lockout (range 1..15).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 tick  input  1  one-clk-wide step strobe from the 1 Hz frequency divider.
REQ-007 code  input  4  candidate passcode.
REQ-008 code_valid  input  1  code presented this cycle.
REQ-009 code_ready  output  1  controller accepts a code this cycle.
REQ-010 data_in  input  4  user data shown on LEDs while unlocked.
REQ-011 relock  input  1  one-cycle request to leave UNLOCKED.
REQ-012 led  output  4  registered LED drive.
REQ-013 busy  output  1  pattern or lockout in progress.
REQ-014 unlocked  output  1  high in UNLOCKED.
REQ-015 locked_out  output  1  high in LOCKOUT.

Function
REQ-016 States SHALL be IDLE, PASS_SEQ, FAIL_SEQ, UNLOCKED, LOCKOUT; step counter is 4 bits.
REQ-017 code_ready SHALL be 1 only in IDLE; a code is accepted on a cycle with code_valid=1 and code_ready=1.
REQ-018 Accept with code==PASSCODE: next state PASS_SEQ, step=0, fail count cleared.
REQ-019 Accept with code!=PASSCODE: next state FAIL_SEQ, step=0, fail count +1, saturating at MAX_FAIL.
REQ-020 A tick on the accept cycle SHALL be ignored; step advances only on ticks while in PASS_SEQ/FAIL_SEQ.
REQ-021 PASS_SEQ led by step 0..8: 0000,0001,0010,0100,1000,0100,0010,0001,0000; tick at step 8 -> UNLOCKED.
REQ-022 FAIL_SEQ led by step 0..6: 0000,1111,0000,1111,0000,1111,0000; tick at step 6 -> LOCKOUT if fail count==MAX_FAIL, else IDLE.
REQ-023 led SHALL equal the pattern for the current step, updated one clk after the step changes.
REQ-024 UNLOCKED: led SHALL follow data_in with one clk of register latency.
REQ-025 UNLOCKED: relock=1 -> IDLE next cycle, led 0000; relock wins over a simultaneous tick.
REQ-026 relock outside UNLOCKED SHALL be ignored.
REQ-027 LOCKOUT: led held 1010; ticks counted; on the LOCKOUT_TICKS-th tick -> IDLE, fail count cleared, led 0000.
REQ-028 IDLE: led SHALL be 0000.
REQ-029 busy SHALL be 1 in PASS_SEQ, FAIL_SEQ, LOCKOUT; unlocked/locked_out SHALL be decoded registered state flags.
REQ-030 code_valid while code_ready=0 SHALL be dropped, with no effect on state or fail count.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, step=0, fail count=0, tick count=0, led=0000, busy=0, unlocked=0, locked_out=0, code_ready=1 after release.
REQ-032 Reset mid-sequence, mid-lockout or while unlocked SHALL abort without completing the pattern; first accept after release behaves as from power-up.

Configuration
REQ-033 Macro LED_SEQ_LOCKOUT_EN defined: fail counter and LOCKOUT state present per REQ-019/022/027.
REQ-034 Macro LED_SEQ_LOCKOUT_EN undefined: no fail counter or LOCKOUT state, FAIL_SEQ always ends in IDLE, locked_out tied 0, MAX_FAIL/LOCKOUT_TICKS unused.

Verification
REQ-035 Code 1001 accepted, 9 ticks -> led 0000,0001,0010,0100,1000,0100,0010,0001,0000, then unlocked=1; data_in=0110 -> led 0110 one clk later.
REQ-036 Code 0011 accepted, 7 ticks -> led alternates 0000/1111 ending 0000, busy 1->0, back to IDLE, code_ready=1.
REQ-037 (LOCKOUT_EN) three wrong codes each run to completion -> locked_out=1, led 1010; after 10 ticks -> IDLE, next wrong code does not re-enter lockout.
REQ-038 Wrong, wrong, correct (1001), then two wrong -> no lockout (fail count reset by correct code).
REQ-039 code_valid with code 1001 during PASS_SEQ step 3 -> ignored, sequence continues unchanged; relock with tick in UNLOCKED -> IDLE, led 0000.
REQ-040 reset pulsed low at PASS_SEQ step 4 -> led 0000, busy 0 immediately, no unlock after release.
